tpu_host_seq: RTL and testbench
===============================

// Module: tpu_host_seq
// PURPOSE
//  Bus initiator for the tpuv1 memory-mapped port. Runs one full matrix job per start pulse:
//  - takes DIM A rows and DIM B words from a valid/ready input stream and writes them into tpuv1;
//  - optionally zeroes the C accumulators, then writes the multiply trigger;
//  - waits out the systolic run, reads C back and emits 2*DIM words on a valid/ready output stream.
// PARAMETERS
//  DIM      8   matrix dimension
//  BITS_AB  8   A/B element width; DIM*BITS_AB must equal DATAW
//  BITS_C   16  C element width; DIM*BITS_C must equal 2*DATAW
//  ADDRW    16  tpuv1 address width
//  DATAW    64  tpuv1 data width
//  WAIT_CYC 3*DIM-1  idle cycles after the trigger write before the first C read
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      reset, asynchronous, active-low
//  start       in   1      1-cycle job request; sampled only in IDLE
//  clr_c       in   1      sampled with start; 1 = zero the C array before the multiply
//  busy        out  1      1 in every state except IDLE
//  done        out  1      1-cycle pulse when the job completes
//  in_valid    in   1      input word valid
//  in_ready    out  1      input accept (1 only in LOAD_A/LOAD_B)
//  in_data     in   DATAW  A rows (row 0 first), then B words (word 0 first)
//  out_valid   out  1      result word valid
//  out_ready   in   1      result accept
//  out_data    out  DATAW  C row0 lo, row0 hi, row1 lo, ... row DIM-1 hi
//  tpu_r_w     out  1      1 = write, 0 = read/idle
//  tpu_addr    out  ADDRW  tpuv1 address
//  tpu_dataIn  out  DATAW  tpuv1 write data
//  tpu_dataOut in   DATAW  tpuv1 read data (combinational from tpu_addr)
// BEHAVIOUR
//  Address map:
//   - A row i = 0x0100+8i; B word j = 0x0200+8j.
//   - C row i lo = 0x0300+16i; C row i hi = 0x0308+16i. Trigger = 0x0400.
//  All tpu_* outputs are registered. Idle bus value is r_w=0, addr=0x0000, dataIn=0.
//  Reset value of every output is 0: busy, done, in_ready, out_valid, out_data, tpu_*. State resets to IDLE.
//  FSM states: IDLE, LOAD_A, LOAD_B, CLR_C, TRIG, WAIT, READ_C, FLUSH.
//   - IDLE: on start, latch clr_c, clear idx, go to LOAD_A. start in any other state is ignored.
//   - LOAD_A: for each handshake (in_valid&in_ready) at edge t, bus shows write of A row idx in cycle t+1.
//     After DIM handshakes go to LOAD_B. No handshake means the bus stays idle; there is no timeout.
//   - LOAD_B: same rule for B words 0..DIM-1. Then go to CLR_C if clr_c was latched, else TRIG.
//   - CLR_C: 2*DIM back-to-back writes of 0 to addresses 0x0300..0x0378, step 8. Then TRIG.
//   - TRIG: one cycle of r_w=1, addr=0x0400, dataIn=0. Then WAIT.
//   - WAIT: bus idle for exactly WAIT_CYC cycles (counter), then READ_C.
//   - READ_C: r_w=0, addr = C address of word k (k = 0..2*DIM-1).
//     - At each edge where (!out_valid || out_ready): out_data<=tpu_dataOut, out_valid<=1, k<=k+1.
//     - Otherwise the address and k hold.
//     - After word 2*DIM-1 is captured, go to FLUSH; the bus returns to idle.
//  FLUSH: once the final out handshake completes, pulse done for 1 cycle and go to IDLE, busy=0.
//  out_valid: clears on handshake unless a new word is captured at the same edge; out_data holds while out_valid&!out_ready.
//  Counters: idx is a log2(DIM) + 1 bit counter; wait counter is sized for WAIT_CYC. No counter wraps within a job.
//  Reset mid-job: async return to IDLE, bus idle immediately, out_valid dropped, partial job discarded.
// TESTING
//  T1: reset mid-READ_C, then a full job -> all outputs 0 during reset; the second job's results are correct.
//  T2: A=I (0x01 at byte i of row i), B words 0x0102..08, clr_c=1, out_ready=1
//      -> 8 A writes at 0x0100..0x0138, 8 B writes at 0x0200..0x0238, 16 zero writes at 0x0300..0x0378;
//      -> trigger at 0x0400; first read exactly WAIT_CYC=23 cycles after trigger;
//      -> 16 out words equal the model product; done pulse follows the last handshake.
//  T3: random in_valid gaps (50%) -> write count and order unchanged; no write occurs without a handshake.
//  T4: out_ready toggled 1-of-3 -> no word lost or duplicated; tpu_addr held while stalled.
//  T5: clr_c=0 run twice with the same A/B -> second result = 2x first (accumulation); no 0x03xx writes in either job.
//  T6: start pulsed during LOAD_B and WAIT -> ignored, exactly one job. Also check a start on the done cycle is ignored (state still FLUSH).

Source files
------------

// File: rtl/tpu_host_seq.sv
// Host sequencer for the tpuv1 memory-mapped port. It streams A/B into the array, optionally
// clears C, triggers the multiply, waits out the systolic run and streams C back out.
module tpu_host_seq #(
    parameter int DIM      = 8,
    parameter int BITS_AB  = 8,
    parameter int BITS_C   = 16,
    parameter int ADDRW    = 16,
    parameter int DATAW    = 64,
    parameter int WAIT_CYC = 3*DIM-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr_c,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);
    localparam int IDXW = $clog2(DIM) + 1;
    localparam int KW   = $clog2(2*DIM) + 1;
    localparam int WCW  = $clog2(WAIT_CYC + 1);

    localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(DIM - 1);
    localparam logic [KW-1:0]    K_LAST    = KW'(2*DIM - 1);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'(WAIT_CYC);
    localparam logic [ADDRW-1:0] A_BASE    = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] B_BASE    = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] C_BASE    = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] TRIG_ADDR = ADDRW'(16'h0400);

    generate
        if (DIM*BITS_AB != DATAW || DIM*BITS_C != 2*DATAW) begin : g_bad_geometry
            $error("tpu_host_seq: DIM, BITS_AB and BITS_C do not fit DATAW");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CLR_C  = 3'd3,
        S_TRIG   = 3'd4,
        S_WAIT   = 3'd5,
        S_READ_C = 3'd6,
        S_FLUSH  = 3'd7
    } state_t;

    state_t           r_state, w_state_next;
    logic             r_clr, w_clr_next;
    logic [IDXW-1:0]  r_idx, w_idx_next;
    logic [KW-1:0]    r_k, w_k_next;
    logic [WCW-1:0]   r_wait, w_wait_next;
    logic             r_tpu_r_w, w_tpu_r_w_next;
    logic [ADDRW-1:0] r_tpu_addr, w_tpu_addr_next;
    logic [DATAW-1:0] r_tpu_data, w_tpu_data_next;
    logic             r_out_valid, w_out_valid_next;
    logic [DATAW-1:0] r_out_data, w_out_data_next;
    logic             r_done, w_done_next;

    logic             w_in_hs;
    logic             w_out_take;
    logic [KW-1:0]    w_k_inc;

    assign in_ready   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_in_hs    = in_valid && in_ready;
    // A new C word may be captured whenever the output register is empty or being drained.
    assign w_out_take = !r_out_valid || out_ready;
    assign w_k_inc    = r_k + KW'(1);

    always_comb begin
        w_state_next     = r_state;
        w_clr_next       = r_clr;
        w_idx_next       = r_idx;
        w_k_next         = r_k;
        w_wait_next      = r_wait;
        w_tpu_r_w_next   = 1'b0;
        w_tpu_addr_next  = '0;
        w_tpu_data_next  = '0;
        w_out_valid_next = r_out_valid && !out_ready;
        w_out_data_next  = r_out_data;
        w_done_next      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clr_next   = clr_c;
                    w_idx_next   = '0;
                    w_state_next = S_LOAD_A;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (w_in_hs) begin
                    w_tpu_r_w_next  = 1'b1;
                    w_tpu_addr_next = ((r_state == S_LOAD_A) ? A_BASE : B_BASE)
                                      + ADDRW'({r_idx, 3'b000});
                    w_tpu_data_next = in_data;
                    if (r_idx == IDX_LAST) begin
                        w_idx_next = '0;
                        w_k_next   = '0;
                        if (r_state == S_LOAD_A) begin
                            w_state_next = S_LOAD_B;
                        end else begin
                            w_state_next = r_clr ? S_CLR_C : S_TRIG;
                        end
                    end else begin
                        w_idx_next = r_idx + IDXW'(1);
                    end
                end
            end
            S_CLR_C: begin
                // Clear words share the C read map: word k sits at C_BASE + 8k.
                w_tpu_r_w_next  = 1'b1;
                w_tpu_addr_next = C_BASE + ADDRW'({r_k, 3'b000});
                if (r_k == K_LAST) begin
                    w_k_next     = '0;
                    w_state_next = S_TRIG;
                end else begin
                    w_k_next = w_k_inc;
                end
            end
            S_TRIG: begin
                w_tpu_r_w_next  = 1'b1;
                w_tpu_addr_next = TRIG_ADDR;
                w_wait_next     = '0;
                w_state_next    = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait == WAIT_LAST) begin
                    w_k_next        = '0;
                    w_tpu_addr_next = C_BASE;
                    w_state_next    = S_READ_C;
                end else begin
                    w_wait_next = r_wait + WCW'(1);
                end
            end
            S_READ_C: begin
                w_tpu_addr_next = r_tpu_addr;
                if (w_out_take) begin
                    w_out_data_next  = tpu_dataOut;
                    w_out_valid_next = 1'b1;
                    if (r_k == K_LAST) begin
                        w_tpu_addr_next = '0;
                        w_state_next    = S_FLUSH;
                    end else begin
                        w_k_next        = w_k_inc;
                        w_tpu_addr_next = C_BASE + ADDRW'({w_k_inc, 3'b000});
                    end
                end
            end
            S_FLUSH: begin
                // done is registered, so it shows in the cycle after the last handshake, still in FLUSH.
                if (r_out_valid && out_ready) begin
                    w_done_next = 1'b1;
                end
                if (!r_out_valid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_clr       <= 1'b0;
            r_idx       <= '0;
            r_k         <= '0;
            r_wait      <= '0;
            r_tpu_r_w   <= 1'b0;
            r_tpu_addr  <= '0;
            r_tpu_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clr       <= w_clr_next;
            r_idx       <= w_idx_next;
            r_k         <= w_k_next;
            r_wait      <= w_wait_next;
            r_tpu_r_w   <= w_tpu_r_w_next;
            r_tpu_addr  <= w_tpu_addr_next;
            r_tpu_data  <= w_tpu_data_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_done      <= w_done_next;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign tpu_r_w    = r_tpu_r_w;
    assign tpu_addr   = r_tpu_addr;
    assign tpu_dataIn = r_tpu_data;

endmodule

// File: tb/tb_tpu_host_seq.sv
// Bench for tpu_host_seq: a behavioural tpuv1 slave plus a matrix-level reference for C.
`timescale 1ns/1ps
module tb_tpu_host_seq;
    localparam int DIM      = 8;
    localparam int BITS_AB  = 8;
    localparam int BITS_C   = 16;
    localparam int ADDRW    = 16;
    localparam int DATAW    = 64;
    localparam int WAIT_CYC = 3*DIM-1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             clr_c = 1'b0;
    logic             busy, done, in_ready, out_valid, tpu_r_w;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [DATAW-1:0] in_data = '0;
    logic [DATAW-1:0] out_data, tpu_dataIn, tpu_dataOut;
    logic [ADDRW-1:0] tpu_addr;

    tpu_host_seq #(.DIM(DIM), .BITS_AB(BITS_AB), .BITS_C(BITS_C), .ADDRW(ADDRW),
                   .DATAW(DATAW), .WAIT_CYC(WAIT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr_c(clr_c), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int tmo   = 0;

    // Stimulus and matrix-level reference: C[i][c] = sum_k A[i][k]*B[k][c], 16-bit wrap.
    logic [DATAW-1:0] stim_a [DIM];
    logic [DATAW-1:0] stim_b [DIM];
    logic [15:0]      exp_c  [DIM][DIM];

    // Behavioural tpuv1 slave.
    logic [DATAW-1:0] a_mem [DIM];
    logic [DATAW-1:0] b_mem [DIM];
    logic [DATAW-1:0] c_w   [2*DIM];
    assign tpu_dataOut = (tpu_addr[15:8] == 8'h03) ? c_w[tpu_addr[6:3]] : '0;

    typedef struct packed { logic [15:0] a; logic [63:0] d; } wr_t;
    wr_t              wlog[$];
    wr_t              ew[$];
    logic [DATAW-1:0] olog[$];
    int               ocyc[$];
    int               cyc = 0;
    int               trig_cyc, first_rd_cyc, done_cyc, done_cnt, hold_viol;
    logic             done_busy;
    logic             prev_stall = 1'b0;
    logic [15:0]      prev_addr = '0;

    task automatic env_write(input logic [15:0] a, input logic [63:0] d);
        if (a[15:8] == 8'h01) a_mem[a[5:3]] = d;
        else if (a[15:8] == 8'h02) b_mem[a[5:3]] = d;
        else if (a[15:8] == 8'h03) c_w[a[6:3]] = d;
        else if (a == 16'h0400) begin
            for (int i = 0; i < DIM; i++) begin
                for (int c = 0; c < DIM; c++) begin
                    int s;
                    s = 0;
                    for (int k = 0; k < DIM; k++) s += int'(a_mem[i][8*k +: 8]) * int'(b_mem[k][8*c +: 8]);
                    c_w[2*i + c/(DIM/2)][16*(c%(DIM/2)) +: 16] += 16'(s);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (tpu_r_w) begin
            wlog.push_back('{a: tpu_addr, d: tpu_dataIn});
            env_write(tpu_addr, tpu_dataIn);
            if (tpu_addr == 16'h0400) trig_cyc = cyc;
        end else if (busy && tpu_addr == 16'h0300 && first_rd_cyc < 0) begin
            first_rd_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            olog.push_back(out_data);
            ocyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
        if (prev_stall && tpu_addr !== prev_addr) hold_viol++;
        prev_stall = out_valid && !out_ready && !tpu_r_w && tpu_addr[15:8] == 8'h03;
        prev_addr  = tpu_addr;
    end

    task automatic clear_logs();
        wlog.delete(); olog.delete(); ocyc.delete();
        trig_cyc = -1; first_rd_cyc = -1; done_cyc = -1; done_cnt = 0; hold_viol = 0; done_busy = 1'b0;
    endtask

    task automatic update_ref(input bit clr);
        for (int i = 0; i < DIM; i++) begin
            for (int c = 0; c < DIM; c++) begin
                int s;
                s = clr ? 0 : int'(exp_c[i][c]);
                for (int k = 0; k < DIM; k++) s += int'(stim_a[i][8*k +: 8]) * int'(stim_b[k][8*c +: 8]);
                exp_c[i][c] = 16'(s);
            end
        end
    endtask

    function automatic logic [DATAW-1:0] exp_word(input int k);
        logic [DATAW-1:0] w;
        w = '0;
        for (int e = 0; e < DIM/2; e++) w[16*e +: 16] = exp_c[k/2][(DIM/2)*(k%2) + e];
        return w;
    endfunction

    task automatic build_exp_writes(input bit clr);
        ew.delete();
        for (int i = 0; i < DIM; i++) ew.push_back('{a: 16'h0100 + 16'(8*i), d: stim_a[i]});
        for (int i = 0; i < DIM; i++) ew.push_back('{a: 16'h0200 + 16'(8*i), d: stim_b[i]});
        if (clr) for (int i = 0; i < 2*DIM; i++) ew.push_back('{a: 16'h0300 + 16'(8*i), d: 64'h0});
        ew.push_back('{a: 16'h0400, d: 64'h0});
    endtask

    task automatic randomize_stim();
        for (int i = 0; i < DIM; i++) begin
            stim_a[i] = {$urandom, $urandom};
            stim_b[i] = {$urandom, $urandom};
        end
    endtask

    task automatic feed(input int gap_pct);
        int w = 0;
        int budget = 0;
        while (w < 2*DIM && budget < 2000) begin
            bit v;
            v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data  = v ? ((w < DIM) ? stim_a[w] : stim_b[w-DIM]) : {$urandom, $urandom};
            @(negedge clk);
            if (in_valid && in_ready) w++;
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0;
        if (w < 2*DIM) tmo++;
    endtask

    task automatic sink(input bit stall, input bit start_on_done);
        int n = 0;
        int budget = 0;
        while (n < 2*DIM && budget < 5000) begin
            out_ready = stall ? (budget % 3 == 0) : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) n++;
            @(posedge clk); #1;
            budget++;
        end
        if (n < 2*DIM) tmo++;
        budget = 0;
        while (budget < 10) begin
            @(negedge clk);
            if (done) break;
            budget++;
        end
        if (budget >= 10) tmo++;
        else if (start_on_done) begin
            start = 1'b1; clr_c = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; clr_c = 1'b0;
        end
    endtask

    task automatic injector();
        int b = 0;
        while (wlog.size() < DIM + 2 && b < 2000) begin @(posedge clk); b++; end
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        b = 0;
        while (trig_cyc < 0 && b < 2000) begin @(posedge clk); b++; end
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (b >= 2000) tmo++;
    endtask

    task automatic run_job(input bit clr, input int gap_pct, input bit stall, input bit inject);
        clear_logs();
        update_ref(clr);
        @(posedge clk); #1 start = 1'b1; clr_c = clr;
        @(posedge clk); #1 start = 1'b0; clr_c = 1'b0;
        fork
            feed(gap_pct);
            sink(stall, inject);
            begin if (inject) injector(); end
        join
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b in_ready=%b out_valid=%b out_data=%h r_w=%b addr=%h dataIn=%h, expected all 0",
                     busy, done, in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({busy, in_ready, tpu_r_w} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b in_ready=%b r_w=%b, expected 000", busy, in_ready, tpu_r_w);
        end
    endtask

    task automatic test_identity();
        for (int i = 0; i < DIM; i++) begin
            stim_a[i] = 64'h1 << (8*i);
            for (int c = 0; c < DIM; c++) stim_b[i][8*c +: 8] = 8'(8*i + c + 1);
        end
        run_job(1'b1, 0, 1'b0, 1'b0);
        build_exp_writes(1'b1);
        n_vec++;
        if (wlog.size() !== ew.size()) begin
            n_err++;
            $display("FAIL t2_write_count: got %0d expected %0d", wlog.size(), ew.size());
        end
        for (int i = 0; i < ew.size() && i < wlog.size(); i++) begin
            n_vec++;
            if (wlog[i] !== ew[i]) begin
                n_err++;
                $display("FAIL t2_write[%0d]: got %h/%h expected %h/%h", i, wlog[i].a, wlog[i].d, ew[i].a, ew[i].d);
            end
        end
        n_vec++;
        if (first_rd_cyc - trig_cyc !== WAIT_CYC + 1) begin
            n_err++;
            $display("FAIL t2_wait_gap: got %0d idle cycles expected %0d", first_rd_cyc - trig_cyc - 1, WAIT_CYC);
        end
        for (int k = 0; k < 2*DIM; k++) begin
            logic [DATAW-1:0] got;
            got = (k < olog.size()) ? olog[k] : 'x;
            n_vec++;
            if (got !== exp_word(k)) begin
                n_err++;
                $display("FAIL t2_out[%0d]: got %h expected %h", k, got, exp_word(k));
            end
        end
        n_vec++;
        if (ocyc.size() != 2*DIM || done_cyc !== ocyc[2*DIM-1] + 1 || done_cnt !== 1 || done_busy !== 1'b1) begin
            n_err++;
            $display("FAIL t2_done: got done_cyc=%0d count=%0d busy=%b, expected one pulse at cycle after last handshake with busy=1",
                     done_cyc, done_cnt, done_busy);
        end
        n_vec++;
        if (tmo !== 0) begin n_err++; $display("FAIL t2_timeout: got %0d expired waits expected 0", tmo); tmo = 0; end
    endtask

    task automatic test_in_gaps();
        randomize_stim();
        run_job(1'b1, 50, 1'b0, 1'b0);
        build_exp_writes(1'b1);
        n_vec++;
        if (wlog.size() !== ew.size()) begin
            n_err++;
            $display("FAIL t3_write_count: got %0d expected %0d", wlog.size(), ew.size());
        end
        for (int i = 0; i < ew.size() && i < wlog.size(); i++) begin
            n_vec++;
            if (wlog[i] !== ew[i]) begin
                n_err++;
                $display("FAIL t3_write[%0d]: got %h/%h expected %h/%h", i, wlog[i].a, wlog[i].d, ew[i].a, ew[i].d);
            end
        end
        for (int k = 0; k < 2*DIM; k++) begin
            logic [DATAW-1:0] got;
            got = (k < olog.size()) ? olog[k] : 'x;
            n_vec++;
            if (got !== exp_word(k)) begin
                n_err++;
                $display("FAIL t3_out[%0d]: got %h expected %h", k, got, exp_word(k));
            end
        end
        n_vec++;
        if (tmo !== 0) begin n_err++; $display("FAIL t3_timeout: got %0d expired waits expected 0", tmo); tmo = 0; end
    endtask

    task automatic test_out_stall();
        randomize_stim();
        run_job(1'b1, 20, 1'b1, 1'b0);
        n_vec++;
        if (olog.size() !== 2*DIM) begin
            n_err++;
            $display("FAIL t4_word_count: got %0d expected %0d", olog.size(), 2*DIM);
        end
        for (int k = 0; k < 2*DIM; k++) begin
            logic [DATAW-1:0] got;
            got = (k < olog.size()) ? olog[k] : 'x;
            n_vec++;
            if (got !== exp_word(k)) begin
                n_err++;
                $display("FAIL t4_out[%0d]: got %h expected %h", k, got, exp_word(k));
            end
        end
        n_vec++;
        if (hold_viol !== 0) begin
            n_err++;
            $display("FAIL t4_addr_hold: got %0d address changes while stalled expected 0", hold_viol);
        end
        n_vec++;
        if (tmo !== 0) begin n_err++; $display("FAIL t4_timeout: got %0d expired waits expected 0", tmo); tmo = 0; end
    endtask

    task automatic test_accumulate();
        randomize_stim();
        for (int i = 0; i < 2*DIM; i++) c_w[i] = '0;
        for (int i = 0; i < DIM; i++) for (int c = 0; c < DIM; c++) exp_c[i][c] = '0;
        for (int run = 0; run < 2; run++) begin
            int clr_writes;
            run_job(1'b0, 25, run[0], 1'b0);
            clr_writes = 0;
            foreach (wlog[i]) if (wlog[i].a[15:8] == 8'h03) clr_writes++;
            n_vec++;
            if (clr_writes !== 0 || wlog.size() !== 2*DIM + 1) begin
                n_err++;
                $display("FAIL t5_writes_run%0d: got %0d C writes, %0d total; expected 0 and %0d", run, clr_writes, wlog.size(), 2*DIM + 1);
            end
            for (int k = 0; k < 2*DIM; k++) begin
                logic [DATAW-1:0] got;
                got = (k < olog.size()) ? olog[k] : 'x;
                n_vec++;
                if (got !== exp_word(k)) begin
                    n_err++;
                    $display("FAIL t5_out_run%0d[%0d]: got %h expected %h", run, k, got, exp_word(k));
                end
            end
        end
        n_vec++;
        if (tmo !== 0) begin n_err++; $display("FAIL t5_timeout: got %0d expired waits expected 0", tmo); tmo = 0; end
    endtask

    task automatic test_start_ignored();
        int trigs = 0;
        int busy_after = 0;
        randomize_stim();
        run_job(1'b1, 0, 1'b0, 1'b1);
        foreach (wlog[i]) if (wlog[i].a == 16'h0400) trigs++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || tpu_r_w) busy_after++;
        end
        n_vec++;
        if (trigs !== 1 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL t6_single_job: got %0d triggers %0d done pulses, expected 1 and 1", trigs, done_cnt);
        end
        n_vec++;
        if (busy_after !== 0) begin
            n_err++;
            $display("FAIL t6_start_on_done: got %0d busy cycles after done, expected 0", busy_after);
        end
        for (int k = 0; k < 2*DIM; k++) begin
            logic [DATAW-1:0] got;
            got = (k < olog.size()) ? olog[k] : 'x;
            n_vec++;
            if (got !== exp_word(k)) begin
                n_err++;
                $display("FAIL t6_out[%0d]: got %h expected %h", k, got, exp_word(k));
            end
        end
        n_vec++;
        if (tmo !== 0) begin n_err++; $display("FAIL t6_timeout: got %0d expired waits expected 0", tmo); tmo = 0; end
    endtask

    task automatic test_reset_mid_read();
        int b = 0;
        randomize_stim();
        clear_logs();
        @(posedge clk); #1 start = 1'b1; clr_c = 1'b1;
        @(posedge clk); #1 start = 1'b0; clr_c = 1'b0;
        out_ready = 1'b0;
        feed(0);
        while (first_rd_cyc < 0 && b < 500) begin @(posedge clk); b++; end
        if (b >= 500) tmo++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn} !== '0) begin
            n_err++;
            $display("FAIL t1_async_reset: got busy=%b out_valid=%b out_data=%h r_w=%b addr=%h, expected all 0",
                     busy, out_valid, out_data, tpu_r_w, tpu_addr);
        end
        @(negedge clk);
        n_vec++;
        if ({busy, out_valid, tpu_r_w, tpu_addr} !== '0) begin
            n_err++;
            $display("FAIL t1_reset_hold: got busy=%b out_valid=%b r_w=%b addr=%h, expected 0", busy, out_valid, tpu_r_w, tpu_addr);
        end
        rst_n = 1'b1;
        randomize_stim();
        run_job(1'b1, 30, 1'b1, 1'b0);
        for (int k = 0; k < 2*DIM; k++) begin
            logic [DATAW-1:0] got;
            got = (k < olog.size()) ? olog[k] : 'x;
            n_vec++;
            if (got !== exp_word(k)) begin
                n_err++;
                $display("FAIL t1_out[%0d]: got %h expected %h", k, got, exp_word(k));
            end
        end
        n_vec++;
        if (tmo !== 0) begin n_err++; $display("FAIL t1_timeout: got %0d expired waits expected 0", tmo); tmo = 0; end
    endtask

    initial begin
        for (int i = 0; i < 2*DIM; i++) c_w[i] = '0;
        clear_logs();
        test_reset();
        test_identity();
        test_in_gaps();
        test_out_stall();
        test_accumulate();
        test_start_ignored();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion after 500000 ns, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
